// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial core arbiter: FSM encoding, default width, error value.
// Optional timeout support in the top level is enabled with FACT_ARB_TIMEOUT_EN.
package factorial_pkg;

  localparam int unsigned FACT_DW = 32;

  // Result returned to a requester whose job was abandoned by the timeout.
  localparam logic [FACT_DW-1:0] FACT_ERR_VAL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fact_state_e;

endpackage

// File: rtl/factorial_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
// Returns both a one-hot grant and its index; any=0 when no request is set.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned j;
      // Modulo keeps out-of-range pointer values harmless for non-power-of-two NREQ.
      j = (32'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any         = 1'b1;
        grant_oh[j] = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/factorial_arbiter.sv
// Round-robin arbiter sharing one HLS factorial core between NREQ requesters, one job in flight.
// Define FACT_ARB_TIMEOUT_EN to add the WAIT-state timeout counter and the sticky timeout_err port.
module factorial_arbiter
  import factorial_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = FACT_DW
`ifdef FACT_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_num,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic               core_start,
  output logic [DW-1:0]      core_num,
  input  logic               core_done,
  input  logic               core_idle,
  input  logic [DW-1:0]      core_return,
  output logic               busy
`ifdef FACT_ARB_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fact_state_e     state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            pick_any;
  logic [DW-1:0]   pick_num;
  logic            rsp_hs;
  logic            tmo_hit;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req       (req_valid),
    .ptr       (ptr),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    pick_num = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_num = req_num[i*DW +: DW];
    end
  end

  assign rsp_hs = (state == ST_RESP) && rsp_ready[grant];

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          tmo_flag;

  // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
  assign tmo_hit = (state == ST_WAIT) && !core_done &&
                   (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wait_cnt <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state != ST_WAIT) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + 1'b1;
      if (tmo_hit) tmo_flag <= 1'b1;
    end
  end

  assign timeout_err = tmo_flag;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any)             state_nxt = ST_START;
      ST_START: if (core_idle)            state_nxt = ST_WAIT;
      ST_WAIT:  if (core_done || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_hs)               state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is masked during reset so no requester sees an accept that never registers.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (!ap_rst) req_ready = pick_oh;
      ST_START: core_start = core_idle;
      ST_RESP:  rsp_valid[grant] = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr      <= IW'(NREQ - 1);
      grant    <= '0;
      core_num <= '0;
      rsp_data <= '0;
    end else begin
      if (state == ST_IDLE && pick_any) begin
        grant    <= pick_idx;
        core_num <= pick_num;
      end
      if (state == ST_WAIT) begin
        if (core_done)    rsp_data <= core_return;
        else if (tmo_hit) rsp_data <= '1;
      end
      if (rsp_hs) ptr <= grant;
    end
  end

endmodule
